// File: rtl/two_one_mux_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register through a resizing 2:1 mux.
// Optional per-requester saturating grant counters are built when ARB_GRANT_CNT_EN is defined.
module two_one_mux_arbiter #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [A_WIDTH-1:0]   a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [B_WIDTH-1:0]   b_data,
    output logic                 b_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_src,
    input  logic                 out_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] a_grant_cnt,
    output logic [CNT_WIDTH-1:0] b_grant_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                 state_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic                   out_src_q;
    logic                   last_src_q;
    logic [OUT_WIDTH-1:0]   a_resized;
    logic [OUT_WIDTH-1:0]   b_resized;
    logic [OUT_WIDTH-1:0]   out_data_d;
    logic                   space_c;
    logic                   grant_a_c;
    logic                   grant_b_c;

    // Payload resizing: zero-extend narrow buses, keep LSBs of wide ones.
    generate
        if (A_WIDTH >= OUT_WIDTH) begin : g_a_trunc
            assign a_resized = a_data[OUT_WIDTH-1:0];
        end else begin : g_a_ext
            assign a_resized = {{(OUT_WIDTH-A_WIDTH){1'b0}}, a_data};
        end
        if (B_WIDTH >= OUT_WIDTH) begin : g_b_trunc
            assign b_resized = b_data[OUT_WIDTH-1:0];
        end else begin : g_b_ext
            assign b_resized = {{(OUT_WIDTH-B_WIDTH){1'b0}}, b_data};
        end
    endgenerate

    // Sole requester wins outright; under contention the one that did not win last goes.
    always_comb begin
        space_c   = (state_q == EMPTY) | out_ready;
        grant_a_c = a_valid & (~b_valid | last_src_q);
        grant_b_c = b_valid & (~a_valid | ~last_src_q);
        a_ready   = rst_n & space_c & grant_a_c;
        b_ready   = rst_n & space_c & grant_b_c;
        out_data_d = grant_b_c ? b_resized : a_resized;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            last_src_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (a_ready || b_ready) begin
                        state_q    <= FULL;
                        out_data_q <= out_data_d;
                        out_src_q  <= b_ready;
                        last_src_q <= b_ready;
                    end
                end
                FULL: begin
                    if (a_ready || b_ready) begin
                        out_data_q <= out_data_d;
                        out_src_q  <= b_ready;
                        last_src_q <= b_ready;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_WIDTH-1:0] a_cnt_q;
    logic [CNT_WIDTH-1:0] b_cnt_q;

    // Saturating handshake counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (a_ready && (a_cnt_q != {CNT_WIDTH{1'b1}})) begin
                a_cnt_q <= a_cnt_q + CNT_WIDTH'(1);
            end
            if (b_ready && (b_cnt_q != {CNT_WIDTH{1'b1}})) begin
                b_cnt_q <= b_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign a_grant_cnt = a_cnt_q;
    assign b_grant_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_two_one_mux_arbiter.sv
// Directed and random checks of two_one_mux_arbiter against a cycle-level reference model.
module tb_two_one_mux_arbiter;

    localparam int unsigned CW = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, out_valid, out_src;
    logic [7:0] out_data;
    logic [CW-1:0] a_cnt, b_cnt;

    logic        n_a_valid, n_b_valid, n_out_ready;
    logic [3:0]  n_a_data;
    logic [11:0] n_b_data;
    logic        n_a_ready, n_b_ready, n_out_valid, n_out_src;
    logic [7:0]  n_out_data;
    logic [CW-1:0] n_a_cnt, n_b_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: held word, round-robin memory, grant counts.
    bit       m_valid;
    int       m_data;
    bit       m_src;
    bit       m_last;
    int       m_ca, m_cb;

    always #5 clk = ~clk;

    two_one_mux_arbiter #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
`ifdef ARB_GRANT_CNT_EN
        , .a_grant_cnt(a_cnt), .b_grant_cnt(b_cnt)
`endif
    );

    two_one_mux_arbiter #(.A_WIDTH(4), .B_WIDTH(12), .OUT_WIDTH(8), .CNT_WIDTH(CW)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .a_valid(n_a_valid), .a_data(n_a_data), .a_ready(n_a_ready),
        .b_valid(n_b_valid), .b_data(n_b_data), .b_ready(n_b_ready),
        .out_valid(n_out_valid), .out_data(n_out_data), .out_src(n_out_src), .out_ready(n_out_ready)
`ifdef ARB_GRANT_CNT_EN
        , .a_grant_cnt(n_a_cnt), .b_grant_cnt(n_b_cnt)
`endif
    );

`ifndef ARB_GRANT_CNT_EN
    assign a_cnt   = '0;
    assign b_cnt   = '0;
    assign n_a_cnt = '0;
    assign n_b_cnt = '0;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_src = 0; m_last = 1; m_ca = 0; m_cb = 0;
    endtask

    // One clock of the main instance: drive, check readies, advance model, check outputs.
    task automatic cycle(input bit av, input int ad, input bit bv, input int bd, input bit ordy);
        bit space, win_a, win_b;
        int sat;
        a_valid = av; a_data = 8'(ad); b_valid = bv; b_data = 8'(bd); out_ready = ordy;
        #3;
        space = !m_valid || ordy;
        win_a = 0; win_b = 0;
        if (space) begin
            if (av && bv) begin
                if (m_last) win_a = 1; else win_b = 1;
            end else if (av) win_a = 1;
            else if (bv) win_b = 1;
        end
        chk("a_ready", int'(a_ready), int'(win_a));
        chk("b_ready", int'(b_ready), int'(win_b));
        sat = (1 << CW) - 1;
        if (win_a || win_b) begin
            m_valid = 1;
            m_data  = (win_a ? ad : bd) % 256;
            m_src   = win_b;
            m_last  = win_b;
            if (win_a && m_ca < sat) m_ca++;
            if (win_b && m_cb < sat) m_cb++;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) begin
            chk("out_data", int'(out_data), m_data);
            chk("out_src", int'(out_src), int'(m_src));
        end
`ifdef ARB_GRANT_CNT_EN
        chk("a_grant_cnt", int'(a_cnt), m_ca);
        chk("b_grant_cnt", int'(b_cnt), m_cb);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1; b_valid = 1; a_data = 8'h11; b_data = 8'h22; out_ready = 1;
        n_a_valid = 0; n_b_valid = 0; n_a_data = '0; n_b_data = '0; n_out_ready = 1;
        model_reset();
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_src", int'(out_src), 0);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_b_ready", int'(b_ready), 0);
        chk("rst_a_cnt", int'(a_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous contention: A first, then strict alternation.
        for (int i = 0; i < 4; i++) cycle(1, 'h11, 1, 'h22, 1);
        // B alone three times, then contention goes to A.
        for (int i = 0; i < 3; i++) cycle(0, 'h11, 1, 'h30 + i, 1);
        cycle(1, 'h44, 1, 'h55, 1);
        // Back-pressure: held word stays put, no readies, then drain and reload together.
        for (int i = 0; i < 4; i++) cycle(1, 'h66, 1, 'h77, 0);
        cycle(1, 'h66, 1, 'h77, 1);
        chk("no_bubble", int'(out_valid), 1);
        cycle(0, 0, 0, 0, 1);
        // A-only streak exercises counter saturation.
        for (int i = 0; i < 5; i++) cycle(1, 'h80 + i, 0, 0, 1);

        // Asynchronous reset mid-cycle while holding a word.
        cycle(1, 'h99, 1, 'hAA, 0);
        a_valid = 1; b_valid = 1; out_ready = 1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_a_ready", int'(a_ready), 0);
        chk("arst_b_ready", int'(b_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 'h12, 1, 'h34, 1);
        chk("post_rst_src", int'(out_src), 0);

        // Width adaptation on the narrow/wide instance.
        n_a_valid = 1; n_a_data = 4'hF; n_b_valid = 0; n_b_data = 12'hABC;
        @(posedge clk);
        #1;
        chk("narrow_a_data", int'(n_out_data), 'h0F);
        chk("narrow_a_src", int'(n_out_src), 0);
        n_a_valid = 0; n_b_valid = 1;
        @(posedge clk);
        #1;
        chk("wide_b_data", int'(n_out_data), 'hBC);
        chk("wide_b_src", int'(n_out_src), 1);
        n_b_valid = 0;

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(1)), int'($urandom_range(255)),
                  1'($urandom_range(1)), int'($urandom_range(255)),
                  1'($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
